instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles to wait for any memory ack before fault.
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr  in  32  instruction word from instruction memory, valid when imem_ack=1; imem_ack  in  1  instruction fetch complete; dmem_ack  in  1  data access complete.
REQ-004 SHALL have ports: imem_req  out  1  fetch request; ir_load  out  1  latch instr into instruction register; pc_enable  out  1  advance PC one step.
REQ-005 SHALL have ports: memRead  out  1  data read strobe, active-low; memWrite  out  1  data write strobe, active-low.
REQ-006 SHALL have ports: regWrite  out  1  register file write; memToReg  out  1  writeback source is memory; ALUSrc  out  1  ALU B operand is immediate; ALUOp  out  5  ALU operation; state_o  out  3  current state; fault  out  1  sticky error flag.

Function
REQ-007 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, FAULT; encoding FETCH=0 through FAULT=5.
REQ-008 FETCH SHALL assert imem_req; on imem_ack=1, assert ir_load that cycle and go to DECODE; otherwise stay.
REQ-009 DECODE SHALL classify the latched instruction by bits [31:29]: 001 ALU, 100 memory (bit24=0 load, 1 store), 010 constant (bits[25:24]=10 loadlit), 000 NOP; any other value, or class 010 with bits[25:24]!=10, is illegal.
REQ-010 DECODE SHALL go to EXEC for ALU, memory, loadlit; to WB for NOP; to FAULT for illegal.
REQ-011 EXEC SHALL hold ALUSrc/ALUOp one cycle, then go to MEM for load/store, else WB.
REQ-012 MEM SHALL drive memRead=0 (load) or memWrite=0 (store) until dmem_ack=1, then go to WB.
REQ-013 WB SHALL assert regWrite for ALU, load, loadlit only; assert pc_enable exactly one cycle; go to FETCH.
REQ-014 ALUOp SHALL be 00000 for all legal classes; ALU class with bits[28:24]!=00000 is illegal.
REQ-015 ALUSrc SHALL be 1 for load, store, loadlit, NOP; 0 for ALU. memToReg SHALL be 1 only for load.
REQ-016 A wait counter (width ceil(log2(MEM_TIMEOUT+1))) SHALL clear on entering FETCH or MEM, increment each waiting cycle, and on reaching MEM_TIMEOUT without ack go to FAULT.
REQ-017 Ack arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL be honoured (normal transition, no fault).
REQ-018 FAULT SHALL set fault=1, drive all strobes inactive (memRead=memWrite=1, others 0) and remain until reset.
REQ-019 Acks received in states not waiting for them SHALL be ignored.
REQ-020 Outputs other than state_o and fault SHALL be combinational decode of state plus registered instruction; no strobe SHALL glitch active outside its state.
REQ-021 Minimum instruction latency SHALL be: NOP 3 cycles, ALU/loadlit 4, load/store 5 (zero-wait acks).

Reset
REQ-022 reset_n=0 SHALL asynchronously force state FETCH, instruction register 0, wait counter 0, fault 0.
REQ-023 During reset outputs SHALL be: memRead=1, memWrite=1, imem_req, ir_load, pc_enable, regWrite, memToReg, ALUSrc 0, ALUOp 00000.
REQ-024 Reset asserted mid-MEM SHALL abort the access immediately; first post-reset action is a fetch at the next rising edge after deassertion.

Structure
REQ-025 State encoding, opcode class codes (001/100/010/000), ALUOp values and MEM_TIMEOUT default SHALL live in shared package lapido_pkg.
REQ-026 Instruction classification SHALL be sub-module instr_class_decode (combinational, 32-bit in, class + load/store + illegal out).

Verification
REQ-027 ALU add 0x20000000, imem_ack and dmem_ack immediate -> states FETCH,DECODE,EXEC,WB; regWrite=1 in WB; pc_enable one pulse; 4 cycles.
REQ-028 Load 0x80000000, dmem_ack after 3 cycles -> memRead=0 for exactly 3 cycles in MEM, memToReg=1, regWrite=1 in WB.
REQ-029 Store 0x81000000 -> memWrite=0 in MEM, regWrite=0 in WB, memRead stays 1 throughout.
REQ-030 Illegal 0xE0000000 -> FAULT after DECODE, fault=1, no pc_enable; stays FAULT until reset_n=0, then FETCH.
REQ-031 Load with no dmem_ack -> FAULT after exactly 15 MEM cycles; repeat with ack on cycle 15 -> WB, fault=0.
REQ-032 reset_n pulsed low during MEM of a store -> memWrite returns to 1 asynchronously, state_o=0, no regWrite or pc_enable.

Source files
------------

// File: rtl/lapido_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// opcode class codes, ALU operation values and the memory timeout default.
package lapido_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Opcode class, instruction bits [31:29]
  localparam logic [2:0] OPC_NOP   = 3'b000;
  localparam logic [2:0] OPC_ALU   = 3'b001;
  localparam logic [2:0] OPC_CONST = 3'b010;
  localparam logic [2:0] OPC_MEM   = 3'b100;

  // Constant-class sub-op, bits [25:24]; only loadlit is defined
  localparam logic [1:0] CONST_LOADLIT = 2'b10;

  // ALU function field, bits [28:24]; only add is defined
  localparam logic [4:0] ALU_FUNC_ADD = 5'b00000;

  localparam int                 ALUOP_W   = 5;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'b00000;

  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/instr_sequencer_if.sv
// Handshake/control bundle between the sequencer and its memories/datapath.
interface instr_sequencer_if;
  import lapido_pkg::*;

  logic [31:0]        instr;
  logic               imem_ack;
  logic               dmem_ack;
  logic               imem_req;
  logic               ir_load;
  logic               pc_enable;
  logic               memRead;
  logic               memWrite;
  logic               regWrite;
  logic               memToReg;
  logic               ALUSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic [2:0]         state_o;
  logic               fault;

  // Sequencer side
  modport master (
    input  instr, imem_ack, dmem_ack,
    output imem_req, ir_load, pc_enable, memRead, memWrite,
           regWrite, memToReg, ALUSrc, ALUOp, state_o, fault
  );

  // Memory/datapath side
  modport slave (
    output instr, imem_ack, dmem_ack,
    input  imem_req, ir_load, pc_enable, memRead, memWrite,
           regWrite, memToReg, ALUSrc, ALUOp, state_o, fault
  );

endinterface

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: opcode class, load/store select
// and legality of the latched instruction word.
module instr_class_decode
  import lapido_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [2:0]  o_cls,
  output logic        o_store,
  output logic        o_illegal
);

  // Operand fields do not affect classification
  logic w_unused;
  assign w_unused = ^i_instr[23:0];

  assign o_cls   = i_instr[31:29];
  assign o_store = i_instr[24];

  // Legality check per class; unknown classes are illegal
  always_comb begin
    o_illegal = 1'b1;
    case (i_instr[31:29])
      OPC_NOP:   o_illegal = 1'b0;
      OPC_ALU:   o_illegal = (i_instr[28:24] != ALU_FUNC_ADD);
      OPC_MEM:   o_illegal = 1'b0;
      OPC_CONST: o_illegal = (i_instr[25:24] != CONST_LOADLIT);
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and
// writeback control with a shared ack timeout and a sticky fault state.
module instr_sequencer
  import lapido_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  instr_sequencer_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           r_state;
  state_e           w_next;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fault;

  logic [2:0] w_cls;
  logic       w_store;
  logic       w_illegal;
  logic       w_is_alu;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_lit;
  logic       w_is_nop;
  logic       w_timeout;
  logic       w_ir_load;

  instr_class_decode u_dec (
    .i_instr   (r_ir),
    .o_cls     (w_cls),
    .o_store   (w_store),
    .o_illegal (w_illegal)
  );

  assign w_is_alu   = !w_illegal && (w_cls == OPC_ALU);
  assign w_is_load  = !w_illegal && (w_cls == OPC_MEM) && !w_store;
  assign w_is_store = !w_illegal && (w_cls == OPC_MEM) &&  w_store;
  assign w_is_lit   = !w_illegal && (w_cls == OPC_CONST);
  assign w_is_nop   = !w_illegal && (w_cls == OPC_NOP);

  // Last waiting cycle: an ack here still wins, otherwise we fault
  assign w_timeout  = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_ir_load  = (r_state == ST_FETCH) && bus.imem_ack;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (bus.imem_ack)  w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_DECODE: begin
        if (w_illegal)     w_next = ST_FAULT;
        else if (w_is_nop) w_next = ST_WB;
        else               w_next = ST_EXEC;
      end
      ST_EXEC:  w_next = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.dmem_ack)   w_next = ST_WB;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_WB:    w_next = ST_FETCH;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_FAULT;
    endcase
  end

  // Instruction register capture and sticky fault flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ir    <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_ir_load)          r_ir    <= bus.instr;
      if (w_next == ST_FAULT) r_fault <= 1'b1;
    end
  end

  // Ack wait counter: cleared on entry to a waiting state, counts while waiting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      if (w_next == ST_FETCH || w_next == ST_MEM) r_wait_cnt <= '0;
    end else if (r_state == ST_FETCH || r_state == ST_MEM) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Control outputs decoded from state and latched instruction; held inactive in reset
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.ir_load   = 1'b0;
    bus.pc_enable = 1'b0;
    bus.memRead   = 1'b1;
    bus.memWrite  = 1'b1;
    bus.regWrite  = 1'b0;
    bus.memToReg  = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.ALUOp     = ALUOP_ADD;
    if (reset_n) begin
      case (r_state)
        ST_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_load  = w_ir_load;
        end
        ST_EXEC: begin
          bus.ALUSrc = !w_is_alu;
          bus.ALUOp  = ALUOP_ADD;
        end
        ST_MEM: begin
          bus.ALUSrc   = !w_is_alu;
          bus.memToReg = w_is_load;
          bus.memRead  = !w_is_load;
          bus.memWrite = !w_is_store;
        end
        ST_WB: begin
          bus.ALUSrc    = !w_is_alu;
          bus.memToReg  = w_is_load;
          bus.regWrite  = w_is_alu || w_is_load || w_is_lit;
          bus.pc_enable = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state_o = r_state;
  assign bus.fault   = r_fault;

endmodule
